// File: rtl/pad_mux_sequencer_if.sv
// Request/response bundle between the pad-config register block and the pad mux sequencer.
interface pad_mux_sequencer_if;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [5:0] req_pad_i;
    logic [1:0] req_func_i;
    logic       req_pull_en_i;
    logic       done_o;
    logic       err_o;
    logic       busy_o;

    modport master (
        output req_valid_i, req_pad_i, req_func_i, req_pull_en_i,
        input  req_ready_o, done_o, err_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_pad_i, req_func_i, req_pull_en_i,
        output req_ready_o, done_o, err_o, busy_o
    );
endinterface

// File: rtl/pad_mux_sequencer.sv
// Per-pad function/pull owner; applies each change as gate-OE, guard, switch, guard, re-enable.
module pad_mux_sequencer #(
    parameter int unsigned NUM_PADS     = 48,
    parameter int unsigned NUM_FUNC     = 4,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pad_mux_sequencer_if.slave    req_if,
    output logic [NUM_PADS*2-1:0] pad_func_o,
    output logic [NUM_PADS*6-1:0] pad_cfg_o,
    output logic [NUM_PADS-1:0]   pad_oe_en_o
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PAD_W  = 6;
    localparam int unsigned FUNC_W = 2;
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SWITCH,
        SETTLE,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PAD_W-1:0]       cap_pad_q, cap_pad_d;
    logic [FUNC_W-1:0]      cap_func_q, cap_func_d;
    logic                   cap_pull_q, cap_pull_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [NUM_PADS*2-1:0]  pad_func_q, pad_func_d;
    logic [NUM_PADS-1:0]    pull_dis_q, pull_dis_d;
    logic [NUM_PADS-1:0]    oe_en_q, oe_en_d;

    logic [NUM_PADS-1:0]    req_sel_c;
    logic [NUM_PADS-1:0]    act_sel_c;
    logic [FUNC_W-1:0]      cur_func_c;
    logic                   cur_pull_dis_c;
    logic                   req_bad_c;

    assign req_bad_c = (32'(req_if.req_pad_i) >= NUM_PADS) ||
                       (32'(req_if.req_func_i) >= NUM_FUNC);

    // Decode requested and captured pad indices; fetch the requested pad's current settings.
    always_comb begin
        req_sel_c      = '0;
        act_sel_c      = '0;
        cur_func_c     = '0;
        cur_pull_dis_c = 1'b0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            if (req_if.req_pad_i == PAD_W'(p)) begin
                req_sel_c[p]   = 1'b1;
                cur_func_c     = pad_func_q[2*p +: 2];
                cur_pull_dis_c = pull_dis_q[p];
            end
            if (cap_pad_q == PAD_W'(p)) begin
                act_sel_c[p] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_pad_d  = cap_pad_q;
        cap_func_d = cap_func_q;
        cap_pull_d = cap_pull_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pad_func_d = pad_func_q;
        pull_dis_d = pull_dis_q;
        oe_en_d    = oe_en_q;

        unique case (state_q)
            IDLE: begin
                if (req_if.req_valid_i && ready_q) begin
                    if (req_bad_c) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if ((req_if.req_func_i == cur_func_c) &&
                                 (req_if.req_pull_en_i == ~cur_pull_dis_c)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = DRAIN;
                        cnt_d      = GUARD_LOAD;
                        cap_pad_d  = req_if.req_pad_i;
                        cap_func_d = req_if.req_func_i;
                        cap_pull_d = req_if.req_pull_en_i;
                        ready_d    = 1'b0;
                        busy_d     = 1'b1;
                        oe_en_d    = oe_en_q & ~req_sel_c;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = SWITCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SWITCH: begin
                state_d = SETTLE;
                cnt_d   = GUARD_LOAD;
                for (int unsigned p = 0; p < NUM_PADS; p++) begin
                    if (act_sel_c[p]) begin
                        pad_func_d[2*p +: 2] = cap_func_q;
                        pull_dis_d[p]        = ~cap_pull_q;
                    end
                end
            end
            SETTLE: begin
                // OE comes back in the same cycle done_o is reported.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    oe_en_d = oe_en_q | act_sel_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_pad_q  <= '0;
            cap_func_q <= '0;
            cap_pull_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pad_func_q <= '0;
            pull_dis_q <= '0;
            oe_en_q    <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_pad_q  <= cap_pad_d;
            cap_func_q <= cap_func_d;
            cap_pull_q <= cap_pull_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pad_func_q <= pad_func_d;
            pull_dis_q <= pull_dis_d;
            oe_en_q    <= oe_en_d;
        end
    end

    // Only bit0 of each pad's config field is live; the rest are tied low.
    always_comb begin
        pad_cfg_o = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            pad_cfg_o[6*p] = pull_dis_q[p];
        end
    end

    assign pad_func_o         = pad_func_q;
    assign pad_oe_en_o        = oe_en_q;
    assign req_if.req_ready_o = ready_q;
    assign req_if.busy_o      = busy_q;
    assign req_if.done_o      = done_q;
    assign req_if.err_o       = err_q;

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// Bench for pad_mux_sequencer: three configurations checked every cycle against a timeline model.
module tb_pad_mux_sequencer;

    localparam int NP = 48;
    localparam int NK = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          valid_r [NK];
    logic [5:0]    pad_r   [NK];
    logic [1:0]    func_r  [NK];
    logic          pull_r  [NK];
    logic          ready_w [NK];
    logic          done_w  [NK];
    logic          err_w   [NK];
    logic          busy_w  [NK];
    logic [2*NP-1:0] pf    [NK];
    logic [6*NP-1:0] pc    [NK];
    logic [NP-1:0]   oe_w  [NK];

    // Instance 0: G=4, 4 funcs. Instance 1: G=1, 4 funcs. Instance 2: G=4, 3 funcs.
    for (genvar k = 0; k < NK; k++) begin : g
        pad_mux_sequencer_if bus ();
        assign bus.req_valid_i   = valid_r[k];
        assign bus.req_pad_i     = pad_r[k];
        assign bus.req_func_i    = func_r[k];
        assign bus.req_pull_en_i = pull_r[k];
        assign ready_w[k]        = bus.req_ready_o;
        assign done_w[k]         = bus.done_o;
        assign err_w[k]          = bus.err_o;
        assign busy_w[k]         = bus.busy_o;

        pad_mux_sequencer #(
            .NUM_PADS    (NP),
            .NUM_FUNC    ((k == 2) ? 3 : 4),
            .GUARD_CYCLES((k == 1) ? 1 : 4)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .req_if     (bus),
            .pad_func_o (pf[k]),
            .pad_cfg_o  (pc[k]),
            .pad_oe_en_o(oe_w[k])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [6*NP-1:0] act, input logic [6*NP-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic int gval(input int k);
        return (k == 1) ? 1 : 4;
    endfunction

    function automatic int nfval(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    // Timeline model: each accepted request is turned into absolute cycle windows.
    int cyc;
    int mfunc    [NK][NP];
    bit mpdis    [NK][NP];
    int rdy_from [NK];
    int done_cyc [NK];
    int lo_from  [NK];
    int lo_to    [NK];
    int act_pad  [NK];
    int sw_cyc   [NK];
    int pend_f   [NK];
    bit pend_pd  [NK];
    bit done_err [NK];
    bit hs       [NK];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            rdy_from[k] = 0;
            done_cyc[k] = -1;
            lo_from[k]  = 1;
            lo_to[k]    = 0;
            act_pad[k]  = -1;
            sw_cyc[k]   = -1;
            done_err[k] = 1'b0;
            hs[k]       = 1'b0;
            for (int p = 0; p < NP; p++) begin
                mfunc[k][p] = 0;
                mpdis[k][p] = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int k);
        int c, p, f, gg;
        c = cyc;
        hs[k] = 1'b0;
        if (valid_r[k] && (c - 1) >= rdy_from[k]) begin
            hs[k] = 1'b1;
            p  = int'(pad_r[k]);
            f  = int'(func_r[k]);
            gg = gval(k);
            if (p >= NP || f >= nfval(k)) begin
                done_cyc[k] = c;
                done_err[k] = 1'b1;
            end else if (mfunc[k][p] == f && mpdis[k][p] == !pull_r[k]) begin
                done_cyc[k] = c;
                done_err[k] = 1'b0;
            end else begin
                act_pad[k]  = p;
                lo_from[k]  = c;
                lo_to[k]    = c + 2*gg;
                sw_cyc[k]   = c + gg + 1;
                pend_f[k]   = f;
                pend_pd[k]  = !pull_r[k];
                done_cyc[k] = c + 2*gg + 1;
                done_err[k] = 1'b0;
                rdy_from[k] = c + 2*gg + 2;
            end
        end
        if (c == sw_cyc[k]) begin
            mfunc[k][act_pad[k]] = pend_f[k];
            mpdis[k][act_pad[k]] = pend_pd[k];
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            cyc++;
            if (rst) model_reset();
            else for (int k = 0; k < NK; k++) model_step(k);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) begin
                logic [2*NP-1:0] ef;
                logic [6*NP-1:0] ec;
                logic [NP-1:0]   eo;
                logic            ed;
                ef = '0;
                ec = '0;
                eo = '1;
                for (int p = 0; p < NP; p++) begin
                    ef[2*p +: 2] = 2'(mfunc[k][p]);
                    ec[6*p]      = mpdis[k][p];
                    if (p == act_pad[k] && cyc >= lo_from[k] && cyc <= lo_to[k]) eo[p] = 1'b0;
                end
                ed = (cyc == done_cyc[k]);
                chk($sformatf("k%0d_ready", k), ready_w[k], cyc >= rdy_from[k]);
                chk($sformatf("k%0d_busy",  k), busy_w[k],  cyc <  rdy_from[k]);
                chk($sformatf("k%0d_done",  k), done_w[k],  ed);
                chk($sformatf("k%0d_err",   k), err_w[k],   ed && done_err[k]);
                chk($sformatf("k%0d_func",  k), pf[k],      ef);
                chk($sformatf("k%0d_cfg",   k), pc[k],      ec);
                chk($sformatf("k%0d_oe",    k), oe_w[k],    eo);
            end
        end
    end

    // Drive one request and hold it until the handshake; reports edges waited.
    task automatic req(input int k, input int pd, input int fn, input bit pl, output int waited);
        @(negedge clk);
        valid_r[k] = 1'b1;
        pad_r[k]   = 6'(pd);
        func_r[k]  = 2'(fn);
        pull_r[k]  = pl;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!hs[k] && waited < 100);
        if (!hs[k]) begin
            total++;
            bad++;
            $display("FAIL k%0d_handshake_timeout got=%0d want<100", k, waited);
        end
        valid_r[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, pd;
        rst = 1'b1;
        for (int k = 0; k < NK; k++) begin
            valid_r[k] = 1'b0;
            pad_r[k]   = '0;
            func_r[k]  = '0;
            pull_r[k]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // No-change: pad 0 already func 0 with pull active.
        req(0, 0, 0, 1'b1, w);
        @(negedge clk);
        chk("nochg_done", done_w[0], 1'b1);
        chk("nochg_err",  err_w[0],  1'b0);
        chk("nochg_oe0",  oe_w[0][0], 1'b1);

        // Errors: pad out of range, and func 3 where only 3 functions exist.
        req(0, 50, 1, 1'b0, w);
        @(negedge clk);
        chk("err_pad_done", done_w[0], 1'b1);
        chk("err_pad_err",  err_w[0],  1'b1);
        req(2, 5, 3, 1'b0, w);
        @(negedge clk);
        chk("err_func_done", done_w[2], 1'b1);
        chk("err_func_err",  err_w[2],  1'b1);
        chk("err_func_pf",   pf[2],     '0);

        // Full sequence, G=4: pad 9 -> func 2, pull off.
        req(0, 9, 2, 1'b0, w);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk($sformatf("full_oe9_t%0d", i),   oe_w[0][9],   (i <= 9) ? 1'b0 : 1'b1);
            chk($sformatf("full_f9_t%0d", i),    pf[0][19:18], (i >= 6) ? 2'd2 : 2'd0);
            chk($sformatf("full_cfg54_t%0d", i), pc[0][54],    i >= 6);
            chk($sformatf("full_done_t%0d", i),  done_w[0],    i == 10);
            chk($sformatf("full_rdy_t%0d", i),   ready_w[0],   i >= 11);
        end

        // Backpressure: second request held from T+1 is accepted in cycle T+11.
        req(0, 12, 1, 1'b1, w);
        req(0, 13, 3, 1'b0, w2);
        chk("bp_wait", 32'(w2), 32'd11);
        repeat (10) @(negedge clk);
        chk("bp_done",  done_w[0],    1'b1);
        chk("bp_f13",   pf[0][27:26], 2'd3);
        chk("bp_cfg78", pc[0][78],    1'b1);
        chk("bp_f12",   pf[0][25:24], 2'd1);

        // Boundary G=1: pad 47 -> func 3.
        req(1, 47, 3, 1'b0, w);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("g1_f47_t%0d", i),   pf[1][95:94], (i >= 3) ? 2'd3 : 2'd0);
            chk($sformatf("g1_done_t%0d", i),  done_w[1],    i == 4);
            chk($sformatf("g1_oe47_t%0d", i),  oe_w[1][47],  i >= 4);
        end

        // Asynchronous reset in the middle of DRAIN.
        req(0, 20, 1, 1'b1, w);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_oe",    oe_w[0],    {NP{1'b1}});
        chk("rst_func",  pf[0],      '0);
        chk("rst_cfg",   pc[0],      '0);
        chk("rst_ready", ready_w[0], 1'b1);
        chk("rst_busy",  busy_w[0],  1'b0);
        chk("rst_done",  done_w[0],  1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        req(0, 20, 1, 1'b1, w);
        repeat (10) @(negedge clk);
        chk("post_rst_done", done_w[0],    1'b1);
        chk("post_rst_f20",  pf[0][41:40], 2'd1);

        // Randomized traffic on every configuration.
        for (int k = 0; k < NK; k++) begin
            repeat (250) begin
                pd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
                req(k, pd, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (15) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
